// File: rtl/ysyx_23060221_ifu_pkg.sv
// rtl/ysyx_23060221_ifu_pkg.sv - shared FSM encoding and constants for the instruction fetch unit
package ysyx_23060221_ifu_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_RESP  = 3'd2,
      S_VALID = 3'd3,
      S_WAIT  = 3'd4
   } ifu_state_e;

   localparam logic [1:0]  RESP_OKAY        = 2'b00;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

   function automatic logic is_aligned(input logic [31:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/ysyx_23060221_ifu_reg.sv
// rtl/ysyx_23060221_ifu_reg.sv - write-enabled register cell with asynchronous reset value
module ysyx_23060221_ifu_reg #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wen_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dout_o <= RESET_VAL;
      end else if (wen_i) begin
         dout_o <= din_i;
      end
   end

endmodule

// File: rtl/ysyx_23060221_ifu.sv
// rtl/ysyx_23060221_ifu.sv - single-outstanding instruction fetch unit feeding decode
module ysyx_23060221_ifu
   import ysyx_23060221_ifu_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            npc_valid,
   input  logic [XLEN-1:0] npc,
   output logic            arvalid,
   output logic [XLEN-1:0] araddr,
   input  logic            arready,
   input  logic            rvalid,
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      rresp,
   output logic            rready,
   output logic            IFU_valid,
   input  logic            IDU_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] pc,
   output logic            fetch_err
);

   ifu_state_e      state_q;
   logic            arvalid_q, rready_q, ifu_valid_q, fetch_err_q;
   logic [XLEN-1:0] inst_q, pc_q, pend_npc_q;
   logic            pend_q;

   logic            handshake, capture, leave_valid, pc_wen, pend_wen, pend_d;
   logic [XLEN-1:0] pc_d;

   // An early npc is parked while the current instruction is still owned by the IFU.
   assign handshake   = (state_q == S_VALID) && ifu_valid_q && IDU_ready;
   assign capture     = npc_valid && !pend_q &&
                        ((state_q == S_RESP) || ((state_q == S_VALID) && !IDU_ready));
   assign leave_valid = handshake && (pend_q || npc_valid);
   assign pc_wen      = leave_valid || ((state_q == S_WAIT) && npc_valid);
   assign pc_d        = ((state_q == S_VALID) && pend_q) ? pend_npc_q : npc;
   assign pend_wen    = capture || handshake;
   assign pend_d      = capture;

   ysyx_23060221_ifu_reg #(.WIDTH(XLEN), .RESET_VAL(RESET_PC)) u_pc_reg (
      .clk_i(clk), .rst_i(rst), .wen_i(pc_wen), .din_i(pc_d), .dout_o(pc_q)
   );

   ysyx_23060221_ifu_reg #(.WIDTH(XLEN), .RESET_VAL('0)) u_pend_npc_reg (
      .clk_i(clk), .rst_i(rst), .wen_i(capture), .din_i(npc), .dout_o(pend_npc_q)
   );

   ysyx_23060221_ifu_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_pend_flag_reg (
      .clk_i(clk), .rst_i(rst), .wen_i(pend_wen), .din_i(pend_d), .dout_o(pend_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         inst_q      <= '0;
         fetch_err_q <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         ifu_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q   <= S_REQ;
               arvalid_q <= is_aligned(pc_q);
            end
            S_REQ: begin
               // A misaligned pc never reaches the bus; it is reported as a fetch fault.
               if (!is_aligned(pc_q)) begin
                  state_q     <= S_VALID;
                  fetch_err_q <= 1'b1;
                  inst_q      <= '0;
                  arvalid_q   <= 1'b0;
                  ifu_valid_q <= 1'b1;
               end else if (arvalid_q && arready) begin
                  state_q   <= S_RESP;
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
               end
            end
            S_RESP: begin
               if (rvalid) begin
                  state_q     <= S_VALID;
                  inst_q      <= (rresp == RESP_OKAY) ? rdata : '0;
                  fetch_err_q <= (rresp != RESP_OKAY);
                  rready_q    <= 1'b0;
                  ifu_valid_q <= 1'b1;
               end
            end
            S_VALID: begin
               if (handshake) begin
                  ifu_valid_q <= 1'b0;
                  if (pend_q || npc_valid) begin
                     state_q     <= S_REQ;
                     fetch_err_q <= 1'b0;
                     arvalid_q   <= is_aligned(pc_d);
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (npc_valid) begin
                  state_q     <= S_REQ;
                  fetch_err_q <= 1'b0;
                  arvalid_q   <= is_aligned(npc);
               end
            end
            default: begin
               state_q     <= S_IDLE;
               arvalid_q   <= 1'b0;
               rready_q    <= 1'b0;
               ifu_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign arvalid   = arvalid_q;
   assign araddr    = pc_q;
   assign rready    = rready_q;
   assign IFU_valid = ifu_valid_q;
   assign inst      = inst_q;
   assign pc        = pc_q;
   assign fetch_err = fetch_err_q;

   illegal_npc_a: assert property (@(posedge clk) disable iff (rst)
      npc_valid |-> !((state_q == S_IDLE) || (state_q == S_REQ) || pend_q));

endmodule
